vec_mem_seq: RTL
================

# vec_mem_seq

Vector memory sequencer for the CVP14 datapath. It transfers one 256-bit vector register (16 × 16-bit lanes) to or from the single-port 16-bit memory bus, one word per cycle. It sits directly downstream of the CPU control FSM: the FSM issues a VLD/VST request with a computed base address, and this block drives `Addr`/`RD`/`WR`/`DataOut`, collects `DataIn`, and returns the loaded vector with a completion pulse.

## Interface
- `NWORDS`, default 16: lanes per vector.
- `WORD_W`, default 16: bits per lane and memory word.
- `RD_LAT`, default 1: cycles from `RD` asserted with `Addr` to `DataIn` valid. Legal range 1..3.

Ports:
- `Clk`  in  1  single clock; all logic on rising edge.
- `Reset_n`  in  1  reset, synchronous, active-low.
- `Start`  in  1  request strobe; sampled only when `Busy`=0.
- `Op`  in  1  0 = VLD (memory→vector), 1 = VST (vector→memory); sampled with `Start`.
- `BaseAddr`  in  16  address of lane 0; sampled with `Start`.
- `VecIn`  in  256  store data; lane i = `VecIn[16i+15:16i]`; sampled with `Start`.
- `VecOut`  out  256  last loaded vector, same lane mapping; held between loads.
- `Busy`  out  1  high from the cycle after an accepted `Start` through the `Done` cycle.
- `Done`  out  1  one-cycle completion pulse.
- `Addr`  out  16  memory address.
- `RD`  out  1  memory read strobe.
- `WR`  out  1  memory write strobe.
- `DataOut`  out  16  memory write data.
- `DataIn`  in  16  memory read data.

## Operation
- States: IDLE, LD_ISSUE, LD_DRAIN, ST_ISSUE, DONE.
- IDLE: `Start`=1 latches `Op`, `BaseAddr`, and `VecIn`, and clears lane counter i. Next state is LD_ISSUE or ST_ISSUE.
- LD_ISSUE:
  - Drive `RD`=1 and `Addr`=`BaseAddr`+i.
  - i increments every cycle; after i=15 go to LD_DRAIN.
  - Each issue pushes a valid bit plus its lane index into an `RD_LAT`-deep pipe.
  - When the pipe output is valid, `DataIn` is captured into internal buffer lane (index) at that edge.
- LD_DRAIN: `RD`=0. Wait until the last lane has been captured, then go to DONE.
- ST_ISSUE:
  - Drive `WR`=1, `Addr`=`BaseAddr`+i, and `DataOut`=latched lane i.
  - After i=15 go to DONE.
- DONE:
  - `Done`=1 and `Busy`=1 for one cycle.
  - For a load, `VecOut` takes the internal buffer at this edge. `VecOut` is therefore atomic and is never partially updated.
  - Next state is IDLE.
- Address arithmetic is 16-bit modulo: `BaseAddr`+i wraps from 0xFFFF to 0x0000.
- `RD` and `WR` are never high together.
- Outside issue cycles: `Addr`=0, `DataOut`=0, `RD`=`WR`=0.
- `Start` while `Busy`=1 is ignored. It has no effect on the current transfer and is not queued.
- A VST leaves `VecOut` unchanged.

## Timing
- `Start` is sampled at edge 0. Cycle 1 is the first issue cycle.
- Load:
  - `RD` is high in cycles 1..16 with addresses `BaseAddr`..`BaseAddr`+15.
  - Lane i is captured at the end of cycle 1+i+`RD_LAT`−1.
  - `Done` is in cycle 17+`RD_LAT`.
- Store:
  - `WR` is high in cycles 1..16.
  - `Done` is in cycle 17.
- A new `Start` is accepted in the cycle after `Done` (IDLE), giving back-to-back transfers with one idle cycle.
- Reset values, driven at the edge where `Reset_n`=0:
  - State IDLE.
  - `Busy`=0, `Done`=0, `RD`=0, `WR`=0, `Addr`=0, `DataOut`=0, `VecOut`=0.
  - Valid pipe cleared.
- Reset mid-transfer aborts the transfer with no `Done`. Memory writes already issued are not undone.

## Structure
- Shared package `cvp14_pkg`: `NWORDS`, `WORD_W`, the state enum `vms_state_t`, and the op encodings `OP_VLD`=0 and `OP_VST`=1.
- One sub-module `vms_valid_pipe`: an `RD_LAT`-stage shift register of {valid, 4-bit lane index}, cleared by `Reset_n`.
- Lane counter, address adder, and lane mux/demux live in the top module.

## Test plan
- **Load, `RD_LAT`=1.** `BaseAddr`=0x0040; memory model returns `addr ^ 0xA5A5`.
  - `RD` is high in cycles 1..16 with `Addr` 0x0040..0x004F.
  - `Done` is in cycle 18.
  - `VecOut` lane i = (0x0040+i) ^ 0xA5A5.
- **Store.** `BaseAddr`=0x0100, `VecIn` lane i = 0x1000+i.
  - `WR` is high in cycles 1..16 with `DataOut` 0x1000..0x100F at `Addr` 0x0100..0x010F.
  - `RD` stays 0 and `Done` is in cycle 17.
- **Wrap.** Load with `BaseAddr`=0xFFF8.
  - Addresses run 0xFFF8..0xFFFF, then 0x0000..0x0007.
  - Lanes 8..15 hold data read from 0x0000..0x0007.
- **Start while Busy.** Pulse `Start` with `Op`=VLD in cycle 5 of a store.
  - Exactly 16 `WR` cycles, 0 `RD` cycles, and a single `Done`.
- **Reset mid-load.** Drive `Reset_n`=0 in cycle 8 of a load.
  - At the next edge: `RD`=0, `Busy`=0, `VecOut`=0, and no `Done`.
  - A subsequent load completes correctly.
- **Latency 3.** Load with `RD_LAT`=3 and a 3-cycle memory model.
  - `Done` is in cycle 20.
  - All 16 lanes are correct, with no lane shift.

Source files
------------

// File: rtl/cvp14_pkg.sv
// Shared CVP14 datapath definitions: vector geometry, memory-op encodings and
// the vector memory sequencer state encoding.
package cvp14_pkg;

    localparam int NWORDS = 16;
    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;

    localparam logic OP_VLD = 1'b0;
    localparam logic OP_VST = 1'b1;

    typedef enum logic [2:0] {
        VMS_IDLE     = 3'd0,
        VMS_LD_ISSUE = 3'd1,
        VMS_LD_DRAIN = 3'd2,
        VMS_ST_ISSUE = 3'd3,
        VMS_DONE     = 3'd4
    } vms_state_t;

endpackage

// File: rtl/vms_valid_pipe.sv
// Read-return tracker: delays {valid, lane} from the issue cycle to the cycle
// in which DataIn for that lane is on the bus, and flags the final lane.
module vms_valid_pipe #(
    parameter int RD_LAT = 1,
    parameter int LANE_W = 4,
    parameter int NWORDS = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              issue,
    input  logic [LANE_W-1:0] issue_lane,
    output logic              cap_valid,
    output logic [LANE_W-1:0] cap_lane,
    output logic              last_done
);

    // Stage 0 is the issue cycle itself: with RD_LAT=1 DataIn arrives in the
    // same cycle as RD, so only RD_LAT-1 registered stages are needed.
    generate
        if (RD_LAT <= 1) begin : g_comb
            assign cap_valid = issue;
            assign cap_lane  = issue_lane;
        end else begin : g_sr
            logic [LANE_W:0] sr [RD_LAT-1];

            always_ff @(posedge Clk) begin
                if (!Reset_n) begin
                    for (int k = 0; k < RD_LAT - 1; k++) begin
                        sr[k] <= '0;
                    end
                end else begin
                    sr[0] <= {issue, issue_lane};
                    for (int k = 1; k < RD_LAT - 1; k++) begin
                        sr[k] <= sr[k-1];
                    end
                end
            end

            assign {cap_valid, cap_lane} = sr[RD_LAT-2];
        end
    endgenerate

    // One cycle after the last lane is written into the buffer.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            last_done <= 1'b0;
        end else begin
            last_done <= cap_valid && (cap_lane == LANE_W'(NWORDS - 1));
        end
    end

endmodule

// File: rtl/vec_mem_seq.sv
// Vector memory sequencer: moves one NWORDS-lane vector register to or from
// the single-port memory bus, one word per cycle, with an atomic VecOut update.
module vec_mem_seq #(
    parameter int NWORDS = cvp14_pkg::NWORDS,
    parameter int WORD_W = cvp14_pkg::WORD_W,
    parameter int RD_LAT = 1
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     Start,
    input  logic                     Op,
    input  logic [15:0]              BaseAddr,
    input  logic [NWORDS*WORD_W-1:0] VecIn,
    output logic [NWORDS*WORD_W-1:0] VecOut,
    output logic                     Busy,
    output logic                     Done,
    output logic [15:0]              Addr,
    output logic                     RD,
    output logic                     WR,
    output logic [WORD_W-1:0]        DataOut,
    input  logic [WORD_W-1:0]        DataIn,
    output logic [2:0]               fsm_state
);
    import cvp14_pkg::*;

    localparam int LANE_W = $clog2(NWORDS);
    localparam int VEC_W  = NWORDS * WORD_W;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NWORDS - 1);

    vms_state_t        state;
    logic [LANE_W-1:0] lane;
    logic [15:0]       base_q;
    logic [VEC_W-1:0]  vec_q;
    logic [VEC_W-1:0]  buf_q;
    logic              issue_rd;
    logic              issue_wr;
    logic              cap_valid;
    logic [LANE_W-1:0] cap_lane;
    logic              last_done;

    assign issue_rd  = (state == VMS_LD_ISSUE);
    assign issue_wr  = (state == VMS_ST_ISSUE);
    assign RD        = issue_rd;
    assign WR        = issue_wr;
    assign Addr      = (issue_rd || issue_wr) ? base_q + 16'(lane) : 16'h0000;
    assign DataOut   = issue_wr ? vec_q[int'(lane)*WORD_W +: WORD_W] : '0;
    assign Busy      = (state != VMS_IDLE);
    assign Done      = (state == VMS_DONE);
    assign fsm_state = state;

    vms_valid_pipe #(
        .RD_LAT (RD_LAT),
        .LANE_W (LANE_W),
        .NWORDS (NWORDS)
    ) u_pipe (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .issue      (issue_rd),
        .issue_lane (lane),
        .cap_valid  (cap_valid),
        .cap_lane   (cap_lane),
        .last_done  (last_done)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state  <= VMS_IDLE;
            lane   <= '0;
            base_q <= '0;
            vec_q  <= '0;
            buf_q  <= '0;
            VecOut <= '0;
        end else begin
            if (cap_valid) begin
                buf_q[int'(cap_lane)*WORD_W +: WORD_W] <= DataIn;
            end

            case (state)
                VMS_IDLE: begin
                    if (Start) begin
                        base_q <= BaseAddr;
                        vec_q  <= VecIn;
                        lane   <= '0;
                        state  <= (Op == OP_VST) ? VMS_ST_ISSUE : VMS_LD_ISSUE;
                    end
                end
                VMS_LD_ISSUE: begin
                    lane <= lane + 1'b1;
                    if (lane == LAST_LANE) begin
                        state <= VMS_LD_DRAIN;
                    end
                end
                VMS_LD_DRAIN: begin
                    // Whole vector published in one edge so readers never see a mix.
                    if (last_done) begin
                        VecOut <= buf_q;
                        state  <= VMS_DONE;
                    end
                end
                VMS_ST_ISSUE: begin
                    lane <= lane + 1'b1;
                    if (lane == LAST_LANE) begin
                        state <= VMS_DONE;
                    end
                end
                VMS_DONE: begin
                    state <= VMS_IDLE;
                end
                default: begin
                    state <= VMS_IDLE;
                end
            endcase
        end
    end

endmodule
